// File: rtl/server_seq_pkg.sv
// Shared definitions for the server operation sequencer: opcodes, per-op
// terminal counts, FSM state encoding and multiplier mode codes.
package server_seq_pkg;

    localparam logic [3:0] OP_DECODE        = 4'd0;
    localparam logic [3:0] OP_ACCUM         = 4'd1;
    localparam logic [3:0] OP_DECRYPT_NONTT = 4'd2;
    localparam logic [3:0] OP_MEM_XFER      = 4'd3;
    localparam logic [3:0] OP_EP_ACC        = 4'd4;
    localparam logic [3:0] OP_EP_GEN        = 4'd5;
    localparam logic [3:0] OP_EXTR_MUL      = 4'd6;
    localparam logic [3:0] OP_INTT          = 4'd7;
    localparam logic [3:0] OP_NTT           = 4'd8;
    localparam logic [3:0] OP_KEYGEN        = 4'd9;
    localparam int         OP_COUNT         = 10;

    localparam logic [1:0] MODE_NTT  = 2'd0;
    localparam logic [1:0] MODE_INTT = 2'd1;
    localparam logic [1:0] MODE_NONE = 2'd2;

    // Fixed window edges that do not scale with the parameters.
    localparam int GEN_LAST     = 99;
    localparam int KG_NTT_FIRST = 100;
    localparam int NTT_LAST     = 257;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_KEYGEN);
    endfunction

    function automatic int op_term(input logic [3:0] op, input int xfer_len, input int ntt_cycle);
        case (op)
            OP_DECODE:        return 64;
            OP_ACCUM:         return 643;
            OP_DECRYPT_NONTT: return 65;
            OP_MEM_XFER:      return 576;
            OP_EP_ACC:        return 131;
            OP_EP_GEN:        return 99;
            OP_EXTR_MUL:      return xfer_len + 7;
            OP_INTT:          return 199;
            OP_NTT:           return 198;
            OP_KEYGEN:        return KG_NTT_FIRST + ntt_cycle;
            default:          return 0;
        endcase
    endfunction

    function automatic int max_term(input int xfer_len, input int ntt_cycle);
        int m;
        m = 0;
        for (int i = 0; i < OP_COUNT; i++) begin
            if (op_term(4'(i), xfer_len, ntt_cycle) > m) m = op_term(4'(i), xfer_len, ntt_cycle);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_window_decode.sv
// Combinational phase-window decode: maps the running op and its count onto
// the secret-gen / NTT strobes, mode and multiplier address/write-enable.
module seq_window_decode
    import server_seq_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int ADDR_W    = 11,
    parameter int N_COEF    = 64,
    parameter int XFER_LEN  = 576,
    parameter int NTT_CYCLE = 192,
    parameter int MULT_LAT  = 6,
    parameter int ADDR_IDLE = 640
) (
    input  logic              i_active,
    input  logic [3:0]        i_op,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_secret_gen,
    output logic              o_ntt_start,
    output logic [1:0]        o_mode,
    output logic [ADDR_W-1:0] o_addr_mult,
    output logic              o_addr_mult_we
);

    logic [31:0] w_c;
    logic        w_is_gen;
    logic        w_is_xfer;

    assign w_c = 32'(i_count);

    always_comb begin
        w_is_gen       = i_active && (i_op == OP_EP_GEN || i_op == OP_KEYGEN);
        w_is_xfer      = i_active && (i_op == OP_EXTR_MUL);
        o_secret_gen   = w_is_gen && (w_c <= GEN_LAST);
        o_ntt_start    = i_active &&
                         (((i_op == OP_NTT) && (w_c <= NTT_LAST)) ||
                          ((i_op == OP_KEYGEN) && (w_c >= KG_NTT_FIRST) &&
                           (w_c <= KG_NTT_FIRST + NTT_CYCLE)));
        o_mode         = MODE_NONE;
        o_addr_mult    = ADDR_W'(ADDR_IDLE);
        o_addr_mult_we = 1'b0;

        if (i_active && i_op == OP_INTT) o_mode = MODE_INTT;
        else if (o_ntt_start)            o_mode = MODE_NTT;

        // Address and write windows key off the generating op, not the
        // secret_gen strobe, so a larger N_COEF extends them past its end.
        if ((w_is_xfer && w_c < XFER_LEN) || (w_is_gen && w_c < N_COEF))
            o_addr_mult = w_c[ADDR_W-1:0];

        if ((w_is_xfer && w_c >= MULT_LAT && w_c < XFER_LEN + MULT_LAT) ||
            (w_is_gen  && w_c >= MULT_LAT && w_c < N_COEF + MULT_LAT))
            o_addr_mult_we = 1'b1;
    end

endmodule

// File: rtl/server_op_sequencer.sv
// Start/busy/done operation sequencer for the server NTT/multiplier datapath:
// one counter per accepted op, abort and illegal-op detection, delayed address taps.
module server_op_sequencer
    import server_seq_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int ADDR_W    = 11,
    parameter int N_COEF    = 64,
    parameter int XFER_LEN  = 576,
    parameter int NTT_CYCLE = 192,
    parameter int MULT_LAT  = 6,
    parameter int ADDR_IDLE = 640
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [3:0]        i_op,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_op_done,
    output logic              o_op_err,
    output logic [CNT_W-1:0]  o_server_counter,
    output logic              o_secret_gen,
    output logic              o_ntt_start,
    output logic [1:0]        o_mode,
    output logic [ADDR_W-1:0] o_addr_mult,
    output logic              o_addr_mult_we,
    output logic [ADDR_W-1:0] o_addr_mult_wr,
    output logic              o_addr_mult_we_reg,
    output logic              o_read_en_mult,
    output logic              o_dbg_state
);

    // Handshake: start is a single-cycle request honoured only in IDLE;
    // busy rises the cycle after acceptance and falls the cycle after
    // op_done or abort; op_err answers an illegal start one cycle later.

    if (max_term(XFER_LEN, NTT_CYCLE) >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the largest terminal count");
    end
    if (ADDR_W < CNT_W || ADDR_IDLE >= (2 ** ADDR_W)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for counter or parked address");
    end

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [3:0]        r_op_q;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_term;
    logic              w_accept;
    logic              w_err;
    logic              w_done;
    logic              w_active;
    logic              r_op_err;
    logic [ADDR_W-1:0] r_addr_wr;
    logic              r_we_reg;
    logic              r_read_en;

    assign w_active = (r_state == ST_RUN);
    assign w_term   = CNT_W'(op_term(r_op_q, XFER_LEN, NTT_CYCLE));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_err    = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (op_legal(i_op)) begin
                        w_next   = ST_RUN;
                        w_accept = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident terminal count.
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (r_count == w_term) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_op_q   <= OP_DECODE;
            r_op_err <= 1'b0;
        end else begin
            r_op_err <= w_err;
            if (w_accept) r_op_q <= i_op;
            if (w_active && w_next == ST_RUN) r_count <= r_count + 1'b1;
            else                              r_count <= '0;
        end
    end

    seq_window_decode #(
        .CNT_W     (CNT_W),
        .ADDR_W    (ADDR_W),
        .N_COEF    (N_COEF),
        .XFER_LEN  (XFER_LEN),
        .NTT_CYCLE (NTT_CYCLE),
        .MULT_LAT  (MULT_LAT),
        .ADDR_IDLE (ADDR_IDLE)
    ) u_decode (
        .i_active       (w_active),
        .i_op           (r_op_q),
        .i_count        (r_count),
        .o_secret_gen   (o_secret_gen),
        .o_ntt_start    (o_ntt_start),
        .o_mode         (o_mode),
        .o_addr_mult    (o_addr_mult),
        .o_addr_mult_we (o_addr_mult_we)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr_wr <= '0;
            r_we_reg  <= 1'b0;
            r_read_en <= 1'b0;
        end else begin
            r_addr_wr <= w_active ? o_addr_mult : '0;
            r_we_reg  <= w_active && o_addr_mult_we;
            r_read_en <= w_active && o_addr_mult[0];
        end
    end

    assign o_busy             = w_active;
    assign o_op_done          = w_done;
    assign o_op_err           = r_op_err;
    assign o_server_counter   = r_count;
    assign o_addr_mult_wr     = r_addr_wr;
    assign o_addr_mult_we_reg = r_we_reg;
    assign o_read_en_mult     = r_read_en;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_server_op_sequencer.sv
// Directed bench for server_op_sequencer: op_done/op_err timing goes through a
// scoreboard queue, phase windows are compared against hand-written ranges.
module tb_server_op_sequencer;
    import server_seq_pkg::*;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0;
    logic [3:0]        i_op = 4'd0;
    logic              o_busy, o_op_done, o_op_err, o_secret_gen, o_ntt_start;
    logic              o_addr_mult_we, o_addr_mult_we_reg, o_read_en_mult, o_dbg_state;
    logic [CNT_W-1:0]  o_server_counter;
    logic [1:0]        o_mode;
    logic [ADDR_W-1:0] o_addr_mult, o_addr_mult_wr;

    logic              d6_start = 1'b0;
    logic [3:0]        d6_op = 4'd0;
    logic              d6_busy, d6_done, d6_err, d6_sg, d6_ntt, d6_we, d6_we_reg, d6_rd, d6_state;
    logic [CNT_W-1:0]  d6_cnt;
    logic [1:0]        d6_mode;
    logic [ADDR_W-1:0] d6_addr, d6_addr_wr;

    server_op_sequencer u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_abort(i_abort),
        .o_busy(o_busy), .o_op_done(o_op_done), .o_op_err(o_op_err),
        .o_server_counter(o_server_counter), .o_secret_gen(o_secret_gen),
        .o_ntt_start(o_ntt_start), .o_mode(o_mode), .o_addr_mult(o_addr_mult),
        .o_addr_mult_we(o_addr_mult_we), .o_addr_mult_wr(o_addr_mult_wr),
        .o_addr_mult_we_reg(o_addr_mult_we_reg), .o_read_en_mult(o_read_en_mult),
        .o_dbg_state(o_dbg_state)
    );

    server_op_sequencer #(.N_COEF(128), .MULT_LAT(3)) u_dut6 (
        .i_clk(clk), .i_rst(i_rst), .i_start(d6_start), .i_op(d6_op), .i_abort(1'b0),
        .o_busy(d6_busy), .o_op_done(d6_done), .o_op_err(d6_err),
        .o_server_counter(d6_cnt), .o_secret_gen(d6_sg),
        .o_ntt_start(d6_ntt), .o_mode(d6_mode), .o_addr_mult(d6_addr),
        .o_addr_mult_we(d6_we), .o_addr_mult_wr(d6_addr_wr),
        .o_addr_mult_we_reg(d6_we_reg), .o_read_en_mult(d6_rd),
        .o_dbg_state(d6_state)
    );

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge: start is sampled on the next edge and
    // the following falling edge is the c=0 cycle, so done lands TERM later.
    task automatic issue(input logic [3:0] op, input int term, input bit expect_done);
        i_start = 1'b1;
        i_op    = op;
        if (expect_done) exp_q.push_back(32'(ncyc + 2 + term));
        tick();
        i_start = 1'b0;
        i_op    = 4'd0;
    endtask

    // Monitor: every falling edge, match op_done / op_err pulses to the queues.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (o_op_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected: op_done at cycle %0d, none expected", ncyc);
                end else begin
                    check("done_cycle", 32'(ncyc), exp_q.pop_front());
                end
            end
            if (o_op_err === 1'b1) begin
                if (err_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL err_unexpected: op_err at cycle %0d, none expected", ncyc);
                end else begin
                    check("err_cycle", 32'(ncyc), err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_counter", o_server_counter, 0);
        check("rst_err", o_op_err, 0);
        check("rst_addr_wr", o_addr_mult_wr, 0);
        check("rst_we_reg", o_addr_mult_we_reg, 0);
        check("rst_read_en", o_read_en_mult, 0);
        check("idle_addr", o_addr_mult, 640);
        check("idle_mode", o_mode, 2);

        // DECODE: done exactly at c=64, then back to idle
        tick();
        issue(OP_DECODE, 64, 1);
        for (int c = 0; c <= 64; c++) begin
            @(negedge clk);
            check("t1_count", o_server_counter, c);
            check("t1_busy", o_busy, 1);
            check("t1_done", o_op_done, (c == 64));
        end
        @(negedge clk);
        check("t1_busy_after", o_busy, 0);
        check("t1_count_after", o_server_counter, 0);

        // EXTR_MUL: address ramp, write window 6..581, one-cycle delayed taps
        tick();
        issue(OP_EXTR_MUL, 583, 1);
        for (int c = 0; c <= 583; c++) begin
            @(negedge clk);
            check("t2_addr", o_addr_mult, (c < 576) ? c : 640);
            check("t2_we", o_addr_mult_we, (c >= 6 && c <= 581));
            check("t2_addr_wr", o_addr_mult_wr, (c == 0) ? 0 : ((c - 1 < 576) ? c - 1 : 640));
            check("t2_we_reg", o_addr_mult_we_reg, (c >= 7 && c <= 582));
            check("t2_read_en", o_read_en_mult, (c >= 1 && c <= 576) ? ((c - 1) % 2) : 0);
        end

        // KEYGEN: secret gen 0..99, NTT window 100..292 in mode 0
        tick();
        issue(OP_KEYGEN, 292, 1);
        for (int c = 0; c <= 292; c++) begin
            @(negedge clk);
            check("t3_secret_gen", o_secret_gen, (c <= 99));
            check("t3_ntt_start", o_ntt_start, (c >= 100));
            check("t3_mode", o_mode, (c >= 100) ? 0 : 2);
            check("t3_done", o_op_done, (c == 292));
        end

        // ACCUM aborted at c=300: no op_done, idle next cycle
        tick();
        issue(OP_ACCUM, 643, 0);
        for (int c = 0; c < 300; c++) @(negedge clk);
        tick();
        i_abort = 1'b1;
        @(negedge clk);
        check("t4_abort_count", o_server_counter, 300);
        check("t4_abort_done", o_op_done, 0);
        tick();
        i_abort = 1'b0;
        @(negedge clk);
        check("t4_abort_busy", o_busy, 0);
        check("t4_abort_count0", o_server_counter, 0);

        // NTT with a start on its op_done cycle: start is dropped
        tick();
        issue(OP_NTT, 198, 1);
        for (int c = 0; c < 198; c++) begin
            @(negedge clk);
            check("t4_ntt_start", o_ntt_start, 1);
            check("t4_ntt_mode", o_mode, 0);
        end
        tick();
        i_start = 1'b1;
        i_op    = OP_DECODE;
        @(negedge clk);
        check("t4_ntt_done", o_op_done, 1);
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("t4_late_start_busy", o_busy, 0);
        @(negedge clk);
        check("t4_late_start_busy2", o_busy, 0);
        check("t4_late_start_count", o_server_counter, 0);

        // INTT: mode 1 throughout, no NTT window
        tick();
        issue(OP_INTT, 199, 1);
        for (int c = 0; c <= 199; c++) begin
            @(negedge clk);
            check("t4_intt_mode", o_mode, 1);
            check("t4_intt_ntt", o_ntt_start, 0);
        end

        // Illegal opcode: single op_err pulse, stays idle
        tick();
        i_start = 1'b1;
        i_op    = 4'hF;
        err_q.push_back(32'(ncyc + 2));
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("t5_err", o_op_err, 1);
        check("t5_err_busy", o_busy, 0);
        @(negedge clk);
        check("t5_err_pulse", o_op_err, 0);
        check("t5_err_busy2", o_busy, 0);

        // EP_GEN interrupted by reset at c=50
        tick();
        issue(OP_EP_GEN, 99, 0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("t5_gen_sg", o_secret_gen, 1);
            check("t5_gen_we", o_addr_mult_we, (c >= 6));
            check("t5_gen_addr", o_addr_mult, c);
        end
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        @(negedge clk);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_count", o_server_counter, 0);
        check("t5_rst_done", o_op_done, 0);
        check("t5_rst_sg", o_secret_gen, 0);
        check("t5_rst_ntt", o_ntt_start, 0);
        check("t5_rst_we", o_addr_mult_we, 0);
        check("t5_rst_addr_wr", o_addr_mult_wr, 0);
        check("t5_rst_we_reg", o_addr_mult_we_reg, 0);
        check("t5_rst_read_en", o_read_en_mult, 0);

        // N_COEF=128, MULT_LAT=3 instance running EP_GEN
        tick();
        d6_start = 1'b1;
        d6_op    = OP_EP_GEN;
        tick();
        d6_start = 1'b0;
        for (int c = 0; c <= 99; c++) begin
            @(negedge clk);
            check("t6_we", d6_we, (c >= 3 && c <= 130));
            check("t6_addr", d6_addr, c);
            check("t6_done", d6_done, (c == 99));
        end
        @(negedge clk);
        check("t6_busy_after", d6_busy, 0);

        tick();
        tick();
        check("done_queue_empty", exp_q.size(), 0);
        check("err_queue_empty", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
